// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit
//   Digit-serial unsigned adder. An accepted Start loads A, B and Cin; the
//   operands are then consumed DIGIT bits per clock, least significant digit
//   first, over N = WIDTH/DIGIT RUN cycles. The final Sum/Carry are
//   registered on the RUN->DONE edge and held until the next completion.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN adds a Sub input. A captured
//   Sub=1 computes A + ~B + 1 (Cin ignored), so Carry=1 means A >= B.
//
// Ports
//   clk    in   clock, all state on rising edge
//   rst    in   synchronous active-high reset
//   Start  in   request, sampled only in IDLE
//   A, B   in   WIDTH-bit operands, captured on accepted Start
//   Cin    in   carry-in, captured on accepted Start
//   Sub    in   (SERIAL_ADDER_SUB_EN only) subtract select, captured with Start
//   Busy   out  high while in RUN
//   Done   out  one-cycle pulse, Sum/Carry valid
//   Sum    out  registered low WIDTH bits of the result
//   Carry  out  registered carry-out of bit WIDTH-1
module serial_adder_nbit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   dig;
  logic [WIDTH-1:0] psum_nx;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as two's complement: invert B, force carry-in to 1.
  assign b_in = Sub ? ~B : B;
  assign c_in = Sub ? 1'b1 : Cin;
`else
  assign b_in = B;
  assign c_in = Cin;
`endif

  // One digit of the add; dig[DIGIT] is the digit carry-out.
  assign dig = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, c_q};

  // New digit enters the partial sum from the MSB side, so after N shifts
  // the first (least significant) digit lands at bit 0.
  assign psum_nx = (psum_q >> DIGIT) | (WIDTH'(dig[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = b_in;
          c_d     = c_in;
          psum_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        c_d    = dig[DIGIT];
        psum_d = psum_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          sum_d   = psum_nx;
          carry_d = dig[DIGIT];
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // Busy/Done decode straight from the state register: glitch-free and
  // mutually exclusive by construction.
  assign Busy  = (state_q == RUN);
  assign Done  = (state_q == DONE);
  assign Sum   = sum_q;
  assign Carry = carry_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Three instances share clk/rst/Start/Cin: 8-bit digit-1, 8-bit digit-4 and
// 3-bit digit-1. Each operation is compared against plain integer arithmetic.
module tb_serial_adder_nbit;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, cin, sub_r;
  logic [7:0] a8, b8;
  logic [2:0] a3, b3;
  logic [2:0] busy, done, carry;
  logic [7:0] s0, s1;
  logic [2:0] s2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .Start(start), .A(a8), .B(b8), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub_r),
`endif
    .Busy(busy[0]), .Done(done[0]), .Sum(s0), .Carry(carry[0]));

  serial_adder_nbit #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .Start(start), .A(a8), .B(b8), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub_r),
`endif
    .Busy(busy[1]), .Done(done[1]), .Sum(s1), .Carry(carry[1]));

  serial_adder_nbit #(.WIDTH(3), .DIGIT(1)) u2 (
    .clk(clk), .rst(rst), .Start(start), .A(a3), .B(b3), .Cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub_r),
`endif
    .Busy(busy[2]), .Done(done[2]), .Sum(s2), .Carry(carry[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {Carry,Sum} of instance d as a 9-bit value
  function automatic logic [8:0] res(input int d);
    case (d)
      0:       return {carry[0], s0};
      1:       return {carry[1], s1};
      default: return {5'd0, carry[2], s2};
    endcase
  endfunction

  // mode 0: plain op; 1: second Start mid-run; 2: reset at cycle 3
  task automatic run_op(input logic [7:0] ia, ib, input logic [2:0] ia3, ib3,
                        input logic ci, sb_in, input int mode);
    int         lat[3] = '{9, 3, 4};
    int         nd[3], dc[3], nb[3];
    logic [8:0] got[3], exp[3];
    logic       sb;
    sb = sb_in & HAS_SUB;
    if (sb) begin
      exp[0] = {1'b0, ia} + {1'b0, ~ib} + 9'd1;
      exp[2] = 9'({1'b0, ia3} + {1'b0, ~ib3} + 4'd1);
    end else begin
      exp[0] = {1'b0, ia} + {1'b0, ib} + 9'(ci);
      exp[2] = 9'({1'b0, ia3} + {1'b0, ib3} + 4'(ci));
    end
    exp[1] = exp[0];
    for (int d = 0; d < 3; d++) begin nd[d] = 0; dc[d] = 0; nb[d] = 0; got[d] = '0; end
    @(negedge clk);
    a8 = ia; b8 = ib; a3 = ia3; b3 = ib3; cin = ci; sub_r = sb; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); a3 = 3'($urandom); b3 = 3'($urandom);
        cin = 1'($urandom); sub_r = 1'($urandom) & HAS_SUB;
      end
      if (mode == 1 && i == 3) begin start = 1'b1; a8 = 8'h10; b8 = 8'h20; end
      if (mode == 1 && i == 4) start = 1'b0;
      if (mode == 2 && i == 4) begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("abort_busy[%0d]", d), 32'(busy[d]), 32'd0);
          chk($sformatf("abort_done[%0d]", d), 32'(done[d]), 32'd0);
          chk($sformatf("abort_res[%0d]", d), 32'(res(d)), 32'd0);
        end
      end
      for (int d = 0; d < 3; d++) begin
        if (busy[d] && done[d]) chk($sformatf("busy_done_excl[%0d]", d), 32'd1, 32'd0);
        if (busy[d]) nb[d]++;
        if (done[d]) begin nd[d]++; dc[d] = i; got[d] = res(d); end
      end
      if (mode == 2 && i == 3) rst = 1'b1;
    end
    for (int d = 0; d < 3; d++) begin
      if (mode == 2 && lat[d] > 3) begin
        chk($sformatf("abort_no_done[%0d]", d), 32'(nd[d]), 32'd0);
      end else begin
        chk($sformatf("done_count[%0d]", d), 32'(nd[d]), 32'd1);
        chk($sformatf("latency[%0d]", d), 32'(dc[d]), 32'(lat[d]));
        chk($sformatf("result[%0d] a=%0h b=%0h ci=%0d sub=%0d", d, ia, ib, ci, sb),
            32'(got[d]), 32'(exp[d]));
        if (mode != 2) chk($sformatf("busy_cycles[%0d]", d), 32'(nb[d]), 32'(lat[d] - 1));
      end
      // Result must still be held well after Done (cleared by an abort reset)
      chk($sformatf("hold[%0d]", d), 32'(res(d)), (mode == 2) ? 32'd0 : 32'(exp[d]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cin = 1'b0; sub_r = 1'b0;
    a8 = '0; b8 = '0; a3 = '0; b3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_done[%0d]", d), 32'(done[d]), 32'd0);
      chk($sformatf("rst_res[%0d]", d), 32'(res(d)), 32'd0);
    end
    rst = 1'b0;

    run_op(8'hFF, 8'h01, 3'd7, 3'd1, 1'b0, 1'b0, 0);  // all-ones wrap
    run_op(8'h3C, 8'h5A, 3'd3, 3'd5, 1'b1, 1'b0, 0);  // 0x97, no carry
    run_op(8'hFF, 8'hFF, 3'd7, 3'd7, 1'b1, 1'b0, 0);  // max operands
    run_op(8'h01, 8'h02, 3'd1, 3'd2, 1'b0, 1'b0, 1);  // ignored mid-run Start
    run_op(8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b0, 2);
    run_op(8'h5A, 8'hA5, 3'd2, 3'd6, 1'b1, 1'b0, 0);  // completes after abort

    // Exhaustive 3-bit {A,B,Cin}; 8-bit instances get random operands
    for (int k = 0; k < 128; k++) begin
      logic [6:0] kk;
      kk = 7'(k);
      run_op(8'($urandom), 8'($urandom), kk[6:4], kk[3:1], kk[0], 1'b0, 0);
    end

    if (HAS_SUB) begin
      run_op(8'd5, 8'd7, 3'd5, 3'd7, 1'b0, 1'b1, 0);  // borrow
      run_op(8'd7, 8'd5, 3'd7, 3'd5, 1'b1, 1'b1, 0);  // no borrow
      run_op(8'd9, 8'd9, 3'd4, 3'd4, 1'b0, 1'b1, 0);  // equal
    end

    for (int k = 0; k < 30; k++)
      run_op(8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_nbit.md
SERIAL_ADDER_NBIT -- requirements
Module: serial_adder_nbit

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits (>=2).
REQ-002 Parameter DIGIT, default 1: bits added per clock; SHALL divide WIDTH exactly; N = WIDTH/DIGIT.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 Start  input  1  request; sampled only in IDLE.
REQ-006 A  input  WIDTH  operand A, captured on accepted Start.
REQ-007 B  input  WIDTH  operand B, captured on accepted Start.
REQ-008 Cin  input  1  carry-in, captured on accepted Start.
REQ-009 Busy  output  1  high while state is RUN.
REQ-010 Done  output  1  single-cycle pulse, result valid.
REQ-011 Sum  output  WIDTH  registered result, low WIDTH bits of A+B+Cin.
REQ-012 Carry  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on Start=1; RUN->DONE after N RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-014 Accepted Start SHALL load A, B, Cin into internal shift/carry registers and clear the digit counter.
REQ-015 Each RUN cycle SHALL add the low DIGIT bits of the A and B shift registers plus the carry register, shift the DIGIT-bit result into the partial-sum register from the MSB side, shift A and B right by DIGIT, and update the carry register.
REQ-016 Sum and Carry SHALL update only on the RUN->DONE edge and hold until the next RUN->DONE edge or reset.
REQ-017 Start sampled high at edge k SHALL produce Done=1 in the cycle after edge k+N (latency N+1 edges), with Sum/Carry valid in that cycle.
REQ-018 Busy SHALL be 1 exactly in the N cycles following acceptance; Busy and Done never both 1.
REQ-019 Start in RUN or DONE SHALL be ignored; no queuing; operand inputs are don't-care outside acceptance.
REQ-020 Start held high continuously SHALL start a new operation each time IDLE is reached (one every N+2 cycles).
REQ-021 Arithmetic SHALL be unsigned; {Carry,Sum} = A+B+Cin exactly, including all-ones wrap-around.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, Busy=0, Done=0, Sum=0, Carry=0, and clear internal registers and counter.
REQ-023 rst during RUN SHALL abort the operation; no Done pulse SHALL follow; rst takes priority over Start in the same cycle.

Configuration
REQ-024 Macro SERIAL_ADDER_SUB_EN: when defined, input port Sub (1 bit) SHALL exist and be captured with Start.
REQ-025 With SERIAL_ADDER_SUB_EN and captured Sub=1, operation SHALL be A + ~B + 1 (Cin ignored); Carry=1 means no borrow (A>=B).
REQ-026 Without SERIAL_ADDER_SUB_EN, the Sub port SHALL be absent and every operation SHALL be A+B+Cin.

Verification
REQ-027 WIDTH=8, DIGIT=1: A=8'hFF, B=8'h01, Cin=0, Start one cycle -> Busy 8 cycles, then Done pulse with Sum=8'h00, Carry=1.
REQ-028 WIDTH=8, DIGIT=4: A=8'h3C, B=8'h5A, Cin=1 -> Busy 2 cycles, Done with Sum=8'h97, Carry=0.
REQ-029 WIDTH=3, DIGIT=1: all 128 {A,B,Cin} combinations sequentially -> every {Carry,Sum} equals A+B+Cin; Done exactly once per operation.
REQ-030 Start pulsed with A=8'h10, B=8'h20 mid-RUN of A=8'h01, B=8'h02 -> second request ignored, result Sum=8'h03, single Done.
REQ-031 rst asserted at RUN cycle 3 of 8 -> next cycle Busy=0, Done=0, Sum=0, Carry=0; no Done follows; new Start then completes normally.
REQ-032 SERIAL_ADDER_SUB_EN defined, WIDTH=8: A=8'd5, B=8'd7, Sub=1 -> Sum=8'hFE, Carry=0; A=8'd7, B=8'd5, Sub=1 -> Sum=8'h02, Carry=1.
